pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, payload width in bits (1..1024).
REQ-002 The block SHALL have parameter RESET_DATA, default 0, the value loaded into every data register on reset.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port clk: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-005 Port rst: input, 1 bit, synchronous, active-low reset.
REQ-006 Port flush: input, 1 bit, synchronous discard of all held entries.
REQ-007 Port in_valid: input, 1 bit, upstream payload valid.
REQ-008 Port in_ready: output, 1 bit, block can accept a payload.
REQ-009 Port in_data: input, WIDTH bits, upstream payload.
REQ-010 Port out_valid: output, 1 bit, out_data holds a valid payload.
REQ-011 Port out_ready: input, 1 bit, downstream accepts the payload.
REQ-012 Port out_data: output, WIDTH bits, head payload.
REQ-013 Port count: output, 2 bits, current occupancy (0..2).

Function
REQ-014 An input transfer SHALL occur when in_valid && in_ready at a clk edge; an output transfer SHALL occur when out_valid && out_ready at a clk edge.
REQ-015 The control FSM SHALL have states EMPTY (count 0), FULL (main register holds data, count 1) and SKID (main and skid registers hold data, count 2).
REQ-016 out_valid SHALL be 1 exactly when state != EMPTY, and out_data SHALL always equal the main register.
REQ-017 From EMPTY: on input transfer, load main <= in_data and go to FULL; otherwise stay.
REQ-018 From FULL: on input only, load skid <= in_data and go to SKID; on output only, go to EMPTY; on both, load main <= in_data and stay FULL; on neither, stay.
REQ-019 From SKID: on output transfer, load main <= skid and go to FULL; otherwise stay.
REQ-020 in_ready SHALL be a registered signal equal to (next state != SKID), so no combinational path exists from out_ready to in_ready.
REQ-021 Latency SHALL be 1 cycle: a payload accepted in EMPTY appears with out_valid=1 on the next cycle.
REQ-022 Sustained throughput SHALL be one transfer per cycle when in_valid and out_ready are both held high.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL stay stable and payload order SHALL be strictly FIFO.
REQ-024 flush=1 SHALL force state to EMPTY, count to 0 and in_ready to 1 on the next edge, overriding any same-cycle input or output transfer.
REQ-025 Any same-cycle input payload SHALL be discarded during a flush; data registers SHALL hold their values.

Reset
REQ-026 With rst=0 at a clk edge, the block SHALL set state EMPTY, out_valid 0, count 0, in_ready 1, and main and skid registers to RESET_DATA.
REQ-027 Reset SHALL take priority over flush and all transfers and SHALL discard in-flight payloads mid-operation.

Configuration
REQ-028 Macro PIPE_STAGE_REG_SKID_EN SHALL select the skid buffer.
REQ-029 With PIPE_STAGE_REG_SKID_EN defined, the block SHALL behave as in REQ-015 to REQ-025.
REQ-030 Without PIPE_STAGE_REG_SKID_EN, the block SHALL omit the skid register and the SKID state, set in_ready = !out_valid || out_ready combinationally, keep count at most 1, and keep all other behaviour unchanged.

Verification
REQ-031 Reset release, in_valid=1, in_data=0xA5A5A5A5, out_ready=1 -> out_valid=1 and out_data=0xA5A5A5A5 next cycle; count=1.
REQ-032 Stream 0x1..0x10 with out_ready=1 constantly -> 16 outputs in order on 16 consecutive cycles, no bubbles.
REQ-033 With the skid buffer enabled, out_ready=0, push 0x11 then 0x22 -> count=2, in_ready=0, out_data=0x11; raise out_ready -> 0x11 then 0x22.
REQ-034 In SKID state, assert flush with in_valid=1 and in_data=0x33 -> next cycle count=0, out_valid=0, in_ready=1; 0x33 is never output.
REQ-035 Drive rst=0 in FULL while in_valid=1 -> next cycle out_valid=0, count=0, out_data=RESET_DATA.
REQ-036 With the skid buffer disabled, out_ready=0 while full -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register; define PIPE_STAGE_REG_SKID_EN to add a skid register and a registered in_ready.
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0] main_q;
    logic in_xfer, out_xfer;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
`ifdef PIPE_STAGE_REG_SKID_EN
    logic [WIDTH-1:0] skid_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_q   <= RESET_DATA;
            skid_q   <= RESET_DATA;
        end else begin
            state    <= nxt;
            in_ready <= nxt != SKID;
            if (!flush) begin
                if (state == SKID && out_xfer)
                    main_q <= skid_q;
                else if (in_xfer && (state == EMPTY || out_xfer))
                    main_q <= in_data;
                if (state == FULL && in_xfer && !out_xfer)
                    skid_q <= in_data;
            end
        end
    end
    always_comb begin
        nxt = flush             ? EMPTY :
              state == EMPTY    ? (in_xfer ? FULL : EMPTY) :
              state == FULL     ? (in_xfer && !out_xfer ? SKID :
                                   !in_xfer && out_xfer ? EMPTY : FULL) :
                                  (out_xfer ? FULL : SKID);
    end
`else
    // Without the skid slot, readiness must follow out_ready in the same cycle.
    assign in_ready = !out_valid || out_ready;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= RESET_DATA;
        end else begin
            state <= nxt;
            if (!flush && in_xfer)
                main_q <= in_data;
        end
    end
    always_comb begin
        nxt = flush    ? EMPTY :
              in_xfer  ? FULL  :
              out_xfer ? EMPTY : state;
    end
`endif
    always_comb begin
        out_valid = state != EMPTY;
        count     = state == SKID ? 2'd2 : state == FULL ? 2'd1 : 2'd0;
        out_data  = main_q;
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-model bench for pipe_stage_reg with directed and random traffic.
module tb_pipe_stage_reg;
    localparam int W = 32;
    localparam logic [W-1:0] RD = 32'hDEADBEEF;
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [W-1:0] in_data = '0;
    logic in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0] count;
    int checks = 0, errors = 0, cyc = 0;
    bit armed = 0, pop_m, push_m;
    logic [W-1:0] q[$];
    logic [W-1:0] main_m = RD;
    logic [W-1:0] log_v[$];
    int log_c[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .RESET_DATA(RD)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count)
    );

    function automatic bit m_in_ready();
        return CAP == 2 ? q.size() < 2 : (q.size() == 0 || out_ready);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: a FIFO of capacity CAP; the main register shows the head, or its last value when empty.
    always @(posedge clk) begin
        cyc++;
        if (rst && !flush && out_valid && out_ready) begin
            log_v.push_back(out_data);
            log_c.push_back(cyc);
        end
        if (!rst) begin
            q.delete();
            main_m = RD;
            armed = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            pop_m  = q.size() > 0 && out_ready;
            push_m = in_valid && m_in_ready();
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back(in_data);
            if (q.size() > 0) main_m = q[0];
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", out_valid, q.size() > 0);
            check("count", count, q.size());
            check("in_ready", in_ready, m_in_ready());
            check("out_data", out_data, main_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit f, input bit iv, input logic [W-1:0] d, input bit ordy);
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    endtask

    initial begin
        drive(0, 0, 0, '0, 0);
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, RD);

        drive(1, 0, 1, 32'hA5A5A5A5, 1);
        tick();
        check("lat_out_valid", out_valid, 1);
        check("lat_out_data", out_data, 32'hA5A5A5A5);
        check("lat_count", count, 1);
        drive(1, 0, 0, '0, 1);
        tick();
        log_v.delete(); log_c.delete();

        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 1, i, 1);
            tick();
        end
        drive(1, 0, 0, '0, 1);
        tick(); tick();
        check("stream_len", log_v.size(), 16);
        for (int i = 0; i < 16 && i < log_v.size(); i++) begin
            check("stream_data", log_v[i], i + 1);
            check("stream_gap", log_c[i] - log_c[0], i);
        end

        log_v.delete(); log_c.delete();
        drive(1, 0, 1, 32'h11, 0);
        tick();
        drive(1, 0, 1, 32'h22, 0);
`ifdef PIPE_STAGE_REG_SKID_EN
        tick();
        check("skid_count", count, 2);
        check("skid_in_ready", in_ready, 0);
        check("skid_out_data", out_data, 32'h11);
        drive(1, 0, 0, '0, 1);
        tick(); tick();
`else
        #1;
        check("full_in_ready_low", in_ready, 0);
        out_ready = 1;
        #1;
        check("full_in_ready_comb", in_ready, 1);
        tick();
        drive(1, 0, 0, '0, 1);
        tick();
`endif
        check("order_len", log_v.size(), 2);
        if (log_v.size() == 2) begin
            check("order_0", log_v[0], 32'h11);
            check("order_1", log_v[1], 32'h22);
        end

        drive(1, 0, 1, 32'h44, 0);
        tick();
`ifdef PIPE_STAGE_REG_SKID_EN
        drive(1, 0, 1, 32'h55, 0);
        tick();
        check("pre_flush_count", count, 2);
`endif
        drive(1, 1, 1, 32'h33, 1);
        tick();
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_hold", out_data, 32'h44);
        log_v.delete(); log_c.delete();
        drive(1, 0, 0, '0, 1);
        tick(); tick();
        drive(1, 0, 1, 32'h66, 1);
        tick();
        drive(1, 0, 0, '0, 1);
        tick();
        check("post_flush_len", log_v.size(), 1);
        if (log_v.size() == 1) check("post_flush_data", log_v[0], 32'h66);

        drive(1, 0, 1, 32'h77, 0);
        tick();
        drive(0, 0, 1, 32'h88, 1);
        tick();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_count", count, 0);
        check("midrst_out_data", out_data, RD);
        check("midrst_in_ready", in_ready, 1);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 59) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
                  $urandom, $urandom_range(0, 9) < 6);
            tick();
        end
        drive(1, 0, 0, '0, 1);
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
